// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the decode/execute/data-memory stage of the
// accumulator core. It holds the opcode enumeration, the idle instruction
// encoding and the default datapath and address widths.
// -----------------------------------------------------------------------------
package exec_pkg;

    localparam int DEF_W  = 8;   // default operand / memory word width
    localparam int DEF_AW = 8;   // default data-memory address width

    // 9'h1FF decodes as HALT, so an idle pipeline never writes state.
    localparam logic [8:0] INST_IDLE = 9'h1FF;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SHL  = 4'b0101,
        OP_SHR  = 4'b0110,
        OP_SET  = 4'b0111,
        OP_LD   = 4'b1000,
        OP_ST   = 4'b1001,
        OP_LDS  = 4'b1010,
        OP_STS  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_BRL  = 4'b1101,
        OP_LUT2 = 4'b1110,
        OP_HALT = 4'b1111
    } op_t;

endpackage

// File: rtl/exec_dmem.sv
// -----------------------------------------------------------------------------
// exec_dmem
// Data memory of 2**AW words of W bits. Reads are asynchronous and writes are
// synchronous. An active-low reset clears every word asynchronously.
// Ports:
//   Clk     - clock (posedge write)
//   Reset   - asynchronous active-low clear; blocks writes while low
//   we_i    - write enable
//   addr_i  - read/write address
//   wdata_i - write data
//   rdata_o - combinational read data at addr_i
// -----------------------------------------------------------------------------
module exec_dmem
    import exec_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2**AW];

    // The clear is in the async branch, so a reset arriving between edges
    // empties the array at once and any write pending for the next edge is lost.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // A read of the address being written returns the old word until the edge.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/exec_ctrl_unit.sv
// -----------------------------------------------------------------------------
// exec_ctrl_unit
// Decode, execute and data-memory stage of the 9-bit-instruction accumulator
// core. It contains a combinational control decoder, a combinational ALU with
// flags and the data memory. Everything except the memory contents is
// combinational, so the outputs follow the inputs in the same cycle.
// Ports:
//   Clk, Reset          - clock and asynchronous active-low reset (memory only)
//   Instruction         - 9-bit instruction: OP=[8:5], Imm=[4:0], short addr=[2:0]
//   InputA / InputB     - register operands; A is the store data, B the address
//   SC_in               - carry-in for ADD/SUB
//   Jump..Ack           - decoded control strobes
//   AluOut, Zero, Parity, Odd - ALU result and its flags
//   MemOut              - data memory read data
//   WrData              - write-back value (AluOut when ALUEn, else MemOut)
// -----------------------------------------------------------------------------
module exec_ctrl_unit
    import exec_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [8:0]   Instruction,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic         SC_in,
    output logic         Jump,
    output logic         BranchEn,
    output logic         BOLEn,
    output logic         RegWrEn,
    output logic         MemWrEn,
    output logic         ALUEn,
    output logic         LUTdm,
    output logic         LUT2x,
    output logic         SetInst,
    output logic         Ack,
    output logic [W-1:0] AluOut,
    output logic         Zero,
    output logic         Parity,
    output logic         Odd,
    output logic [W-1:0] MemOut,
    output logic [W-1:0] WrData
);

    op_t           op;
    logic [4:0]    imm;
    logic [AW-1:0] mem_addr;

    assign op  = op_t'(Instruction[8:5]);
    assign imm = Instruction[4:0];

    // Control decoder
    always_comb begin
        Jump     = 1'b0;
        BranchEn = 1'b0;
        BOLEn    = 1'b0;
        RegWrEn  = 1'b0;
        MemWrEn  = 1'b0;
        ALUEn    = 1'b0;
        LUTdm    = 1'b0;
        LUT2x    = 1'b0;
        SetInst  = 1'b0;
        Ack      = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR: begin
                RegWrEn = 1'b1;
                ALUEn   = 1'b1;
            end
            OP_SET: begin
                SetInst = 1'b1;
                ALUEn   = 1'b1;
            end
            OP_LD:   RegWrEn = 1'b1;
            OP_ST:   MemWrEn = 1'b1;
            OP_LDS: begin
                RegWrEn = 1'b1;
                LUTdm   = 1'b1;
            end
            OP_STS: begin
                MemWrEn = 1'b1;
                LUTdm   = 1'b1;
            end
            OP_JMP:  Jump = 1'b1;
            OP_BRL: begin
                BranchEn = 1'b1;
                BOLEn    = 1'b1;
            end
            OP_LUT2: begin
                RegWrEn = 1'b1;
                LUT2x   = 1'b1;
            end
            OP_HALT: Ack = 1'b1;
            default: ;
        endcase
    end

    // ALU. Results are truncated to W bits and the carry-out is dropped.
    // ADD adds (SC_in-1): all ones when SC_in=0, zero when SC_in=1.
    always_comb begin
        AluOut = '0;
        case (op)
            OP_ADD: AluOut = InputA + InputB + {W{~SC_in}};
            OP_SUB: AluOut = InputA + ~InputB + {{(W-1){1'b0}}, SC_in};
            OP_AND: AluOut = InputA & InputB;
            OP_OR:  AluOut = InputA | InputB;
            OP_XOR: AluOut = InputA ^ InputB;
            OP_SHL: AluOut = InputA << 1;
            OP_SHR: AluOut = InputA >> 1;
            OP_SET: AluOut = {{(W-5){1'b0}}, imm};
            default: AluOut = '0;
        endcase
    end

    assign Zero   = (AluOut == '0);
    assign Parity = ^AluOut;
    assign Odd    = AluOut[0];

    // Short-address ops reach the low eight words without a register operand.
    assign mem_addr = LUTdm ? {{(AW-3){1'b0}}, Instruction[2:0]} : InputB[AW-1:0];

    exec_dmem #(
        .W  (W),
        .AW (AW)
    ) u_dmem (
        .Clk     (Clk),
        .Reset   (Reset),
        .we_i    (MemWrEn),
        .addr_i  (mem_addr),
        .wdata_i (InputA),
        .rdata_o (MemOut)
    );

    assign WrData = ALUEn ? AluOut : MemOut;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
module tb_exec_ctrl_unit;
    import exec_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [8:0] Instruction;
    logic [7:0] InputA, InputB;
    logic       SC_in;
    logic       Jump, BranchEn, BOLEn, RegWrEn, MemWrEn, ALUEn;
    logic       LUTdm, LUT2x, SetInst, Ack;
    logic [7:0] AluOut, MemOut, WrData;
    logic       Zero, Parity, Odd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    exec_ctrl_unit #(.W(8), .AW(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Instruction (Instruction),
        .InputA      (InputA),
        .InputB      (InputB),
        .SC_in       (SC_in),
        .Jump        (Jump),
        .BranchEn    (BranchEn),
        .BOLEn       (BOLEn),
        .RegWrEn     (RegWrEn),
        .MemWrEn     (MemWrEn),
        .ALUEn       (ALUEn),
        .LUTdm       (LUTdm),
        .LUT2x       (LUT2x),
        .SetInst     (SetInst),
        .Ack         (Ack),
        .AluOut      (AluOut),
        .Zero        (Zero),
        .Parity      (Parity),
        .Odd         (Odd),
        .MemOut      (MemOut),
        .WrData      (WrData)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] probe(string t);
        case (t)
            "Jump":     return {15'd0, Jump};
            "BranchEn": return {15'd0, BranchEn};
            "BOLEn":    return {15'd0, BOLEn};
            "RegWrEn":  return {15'd0, RegWrEn};
            "MemWrEn":  return {15'd0, MemWrEn};
            "ALUEn":    return {15'd0, ALUEn};
            "LUTdm":    return {15'd0, LUTdm};
            "LUT2x":    return {15'd0, LUT2x};
            "SetInst":  return {15'd0, SetInst};
            "Ack":      return {15'd0, Ack};
            "AluOut":   return {8'd0, AluOut};
            "Zero":     return {15'd0, Zero};
            "Parity":   return {15'd0, Parity};
            "Odd":      return {15'd0, Odd};
            "MemOut":   return {8'd0, MemOut};
            "WrData":   return {8'd0, WrData};
            default:    return 16'hDEAD;
        endcase
    endfunction

    task automatic push(input string tag, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then pop every pending expectation.
    task automatic compare_all(input string step);
        exp_t        e;
        logic [15:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = probe(e.tag);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s/%s observed=%h expected=%h", step, e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] low,
                         input logic [7:0] a, input logic [7:0] b, input logic sc);
        Instruction = {op, low};
        InputA      = a;
        InputB      = b;
        SC_in       = sc;
    endtask

    task automatic alu_step(input string name, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic sc, input logic [7:0] res,
                            input logic z, input logic p, input logic o);
        @(negedge Clk);
        drive(op, 5'd0, a, b, sc);
        push("AluOut", {8'd0, res});
        push("WrData", {8'd0, res});
        push("Zero", {15'd0, z});
        push("Parity", {15'd0, p});
        push("Odd", {15'd0, o});
        push("ALUEn", 16'd1);
        push("RegWrEn", 16'd1);
        compare_all(name);
    endtask

    initial begin
        // Reset state: memory cleared, LD of address 5 reads zero.
        Reset = 1'b0;
        drive(4'b1000, 5'd0, 8'h00, 8'h05, 1'b1);
        #2;
        push("MemOut", 16'h0000);
        compare_all("reset_rd");
        @(negedge Clk);
        Reset = 1'b1;
        push("MemOut", 16'h0000);
        push("WrData", 16'h0000);
        push("RegWrEn", 16'd1);
        push("ALUEn", 16'd0);
        push("AluOut", 16'h0000);
        compare_all("ld_after_reset");

        // ST A5 -> [10]; the old value is visible until the edge.
        @(negedge Clk);
        drive(4'b1001, 5'd0, 8'hA5, 8'h10, 1'b1);
        push("MemWrEn", 16'd1);
        push("RegWrEn", 16'd0);
        push("MemOut", 16'h0000);
        compare_all("st_pre_edge");
        @(posedge Clk);
        @(negedge Clk);
        drive(4'b1000, 5'd0, 8'h00, 8'h10, 1'b1);
        push("MemOut", 16'h00A5);
        push("WrData", 16'h00A5);
        push("MemWrEn", 16'd0);
        compare_all("ld_after_st");

        // ALU operations: name, op, A, B, SC_in, result, Zero, Parity, Odd.
        alu_step("sub_eq",  4'b0001, 8'h03, 8'h03, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        alu_step("add_wrap",4'b0000, 8'hFF, 8'h02, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        alu_step("add_sc0", 4'b0000, 8'h10, 8'h05, 1'b0, 8'h14, 1'b0, 1'b0, 1'b0);
        alu_step("sub_sc0", 4'b0001, 8'h05, 8'h03, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
        alu_step("and",     4'b0010, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        alu_step("or",      4'b0011, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0);
        alu_step("xor",     4'b0100, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
        alu_step("shl",     4'b0101, 8'h81, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
        alu_step("shr",     4'b0110, 8'h81, 8'h00, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0);

        // SET immediate.
        @(negedge Clk);
        drive(4'b0111, 5'h1B, 8'h55, 8'h66, 1'b1);
        push("AluOut", 16'h001B);
        push("WrData", 16'h001B);
        push("SetInst", 16'd1);
        push("RegWrEn", 16'd0);
        push("ALUEn", 16'd1);
        compare_all("set");

        // STS to short address 6; InputB points elsewhere and must be ignored.
        @(negedge Clk);
        drive(4'b1011, 5'b00110, 8'h3C, 8'h10, 1'b1);
        push("LUTdm", 16'd1);
        push("MemWrEn", 16'd1);
        push("AluOut", 16'h0000);
        compare_all("sts");
        @(posedge Clk);
        @(negedge Clk);
        drive(4'b1010, 5'b00110, 8'h00, 8'h10, 1'b1);
        push("MemOut", 16'h003C);
        push("WrData", 16'h003C);
        push("LUTdm", 16'd1);
        push("RegWrEn", 16'd1);
        compare_all("lds_readback");
        @(negedge Clk);
        drive(4'b1000, 5'd0, 8'h00, 8'h10, 1'b1);
        push("MemOut", 16'h00A5);
        compare_all("ld_10_kept");

        // Idle encoding: no writes, memory unchanged across an edge.
        @(negedge Clk);
        Instruction = INST_IDLE;
        InputA = 8'h77;
        InputB = 8'h10;
        push("Ack", 16'd1);
        push("RegWrEn", 16'd0);
        push("MemWrEn", 16'd0);
        push("AluOut", 16'h0000);
        push("Zero", 16'd1);
        compare_all("idle");
        @(posedge Clk);
        @(negedge Clk);
        drive(4'b1000, 5'd0, 8'h00, 8'h10, 1'b1);
        push("MemOut", 16'h00A5);
        compare_all("idle_no_write");
        @(negedge Clk);
        drive(4'b1010, 5'b00111, 8'h00, 8'h10, 1'b1);
        push("MemOut", 16'h0000);
        compare_all("idle_no_write_s7");

        // Control flow ops.
        @(negedge Clk);
        drive(4'b1101, 5'd0, 8'h00, 8'h00, 1'b1);
        push("BranchEn", 16'd1);
        push("BOLEn", 16'd1);
        push("Jump", 16'd0);
        compare_all("brl");
        @(negedge Clk);
        drive(4'b1100, 5'd0, 8'h00, 8'h00, 1'b1);
        push("Jump", 16'd1);
        push("BranchEn", 16'd0);
        push("RegWrEn", 16'd0);
        compare_all("jmp");
        @(negedge Clk);
        drive(4'b1110, 5'd0, 8'h12, 8'h34, 1'b1);
        push("LUT2x", 16'd1);
        push("RegWrEn", 16'd1);
        push("ALUEn", 16'd0);
        push("AluOut", 16'h0000);
        compare_all("lut2");

        // Reset mid-cycle with a store pending clears memory without an edge.
        @(negedge Clk);
        drive(4'b1001, 5'd0, 8'h5A, 8'h10, 1'b1);
        push("MemOut", 16'h00A5);
        push("MemWrEn", 16'd1);
        compare_all("st_pending");
        #1;
        Reset = 1'b0;
        push("MemOut", 16'h0000);
        compare_all("async_clear");
        @(posedge Clk);
        @(negedge Clk);
        push("MemOut", 16'h0000);
        compare_all("clear_held");
        Reset = 1'b1;
        drive(4'b1000, 5'd0, 8'h00, 8'h10, 1'b1);
        push("MemOut", 16'h0000);
        compare_all("ld_after_clear");
        @(negedge Clk);
        drive(4'b1010, 5'b00110, 8'h00, 8'h00, 1'b1);
        push("MemOut", 16'h0000);
        compare_all("lds6_after_clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is short; anything longer is a hang.
    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
